// File: rtl/ecc_scalar_mult_ctrl.sv
// ecc_scalar_mult_ctrl: MSB-first double-and-add sequencer for Q = k*P.
// Point doubling and addition run in external units through start/done handshakes.
// qx/qy/q_inf double as the running accumulator and hold the final result once done pulses.
module ecc_scalar_mult_ctrl #(
  parameter int unsigned n = 231
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] k,
  input  logic [n-1:0] px,
  input  logic [n-1:0] py,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] qx,
  output logic [n-1:0] qy,
  output logic         q_inf,
  output logic         dbl_start,
  output logic [n-1:0] dbl_x,
  output logic [n-1:0] dbl_y,
  input  logic         dbl_done,
  input  logic [n-1:0] dbl_x3,
  input  logic [n-1:0] dbl_y3,
  input  logic         dbl_inf,
  output logic         add_start,
  output logic [n-1:0] add_x1,
  output logic [n-1:0] add_y1,
  output logic [n-1:0] add_x2,
  output logic [n-1:0] add_y2,
  input  logic         add_done,
  input  logic [n-1:0] add_x3,
  input  logic [n-1:0] add_y3,
  input  logic         add_inf
);

  localparam int unsigned IDX_W = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DBL,
    S_DBL_WAIT,
    S_BIT,
    S_ADD,
    S_ADD_WAIT,
    S_FIN
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [n-1:0]       k_r;
  logic [n-1:0]       px_r;
  logic [n-1:0]       py_r;
  logic [IDX_W-1:0]   idx;

  logic [n-1:0]       k_next;
  logic [n-1:0]       px_next;
  logic [n-1:0]       py_next;
  logic [IDX_W-1:0]   idx_next;
  logic [n-1:0]       qx_next;
  logic [n-1:0]       qy_next;
  logic               q_inf_next;
  logic               busy_next;
  logic               done_next;
  logic               dbl_start_next;
  logic [n-1:0]       dbl_x_next;
  logic [n-1:0]       dbl_y_next;
  logic               add_start_next;
  logic [n-1:0]       add_x1_next;
  logic [n-1:0]       add_y1_next;
  logic [n-1:0]       add_x2_next;
  logic [n-1:0]       add_y2_next;

  logic               k_bit;
  logic               idx_zero;

  assign k_bit    = k_r[idx];
  assign idx_zero = (idx == '0);

  // State, datapath and registered outputs; reset clears everything and aborts any operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      k_r       <= '0;
      px_r      <= '0;
      py_r      <= '0;
      idx       <= '0;
      qx        <= '0;
      qy        <= '0;
      q_inf     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbl_start <= 1'b0;
      dbl_x     <= '0;
      dbl_y     <= '0;
      add_start <= 1'b0;
      add_x1    <= '0;
      add_y1    <= '0;
      add_x2    <= '0;
      add_y2    <= '0;
    end else begin
      state     <= state_next;
      k_r       <= k_next;
      px_r      <= px_next;
      py_r      <= py_next;
      idx       <= idx_next;
      qx        <= qx_next;
      qy        <= qy_next;
      q_inf     <= q_inf_next;
      busy      <= busy_next;
      done      <= done_next;
      dbl_start <= dbl_start_next;
      dbl_x     <= dbl_x_next;
      dbl_y     <= dbl_y_next;
      add_start <= add_start_next;
      add_x1    <= add_x1_next;
      add_y1    <= add_y1_next;
      add_x2    <= add_x2_next;
      add_y2    <= add_y2_next;
    end
  end

  // Sequencing: find the leading one, then double per bit and add on each set bit
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (start) state_next = S_SCAN;
      S_SCAN: begin
        if (k_bit)          state_next = idx_zero ? S_FIN : S_DBL;
        else if (idx_zero)  state_next = S_FIN;
      end
      S_DBL:      state_next = q_inf ? S_BIT : S_DBL_WAIT;
      S_DBL_WAIT: if (dbl_done) state_next = S_BIT;
      S_BIT: begin
        if (k_bit)          state_next = S_ADD;
        else                state_next = idx_zero ? S_FIN : S_DBL;
      end
      S_ADD: begin
        if (q_inf)          state_next = idx_zero ? S_FIN : S_DBL;
        else                state_next = S_ADD_WAIT;
      end
      S_ADD_WAIT: if (add_done) state_next = idx_zero ? S_FIN : S_DBL;
      S_FIN:      state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Next values for datapath and outputs; unit operands change only when a start is issued
  always_comb begin
    k_next         = k_r;
    px_next        = px_r;
    py_next        = py_r;
    idx_next       = idx;
    qx_next        = qx;
    qy_next        = qy;
    q_inf_next     = q_inf;
    busy_next      = (state_next != S_IDLE);
    done_next      = (state_next == S_FIN);
    dbl_start_next = 1'b0;
    dbl_x_next     = dbl_x;
    dbl_y_next     = dbl_y;
    add_start_next = 1'b0;
    add_x1_next    = add_x1;
    add_y1_next    = add_y1;
    add_x2_next    = add_x2;
    add_y2_next    = add_y2;
    case (state)
      S_IDLE: begin
        if (start) begin
          k_next   = k;
          px_next  = px;
          py_next  = py;
          idx_next = IDX_W'(n - 1);
        end
      end
      S_SCAN: begin
        if (k_bit) begin
          qx_next    = px_r;
          qy_next    = py_r;
          q_inf_next = 1'b0;
        end else if (!idx_zero) begin
          idx_next   = idx - IDX_W'(1);
        end else begin
          q_inf_next = 1'b1;
        end
      end
      S_DBL: begin
        if (!idx_zero) idx_next = idx - IDX_W'(1);
        // Doubling infinity is infinity, so the unit is skipped
        if (!q_inf) begin
          dbl_start_next = 1'b1;
          dbl_x_next     = qx;
          dbl_y_next     = qy;
        end
      end
      S_DBL_WAIT: begin
        if (dbl_done) begin
          qx_next    = dbl_x3;
          qy_next    = dbl_y3;
          q_inf_next = dbl_inf;
        end
      end
      S_ADD: begin
        // Infinity + P is P, so the unit is skipped
        if (q_inf) begin
          qx_next    = px_r;
          qy_next    = py_r;
          q_inf_next = 1'b0;
        end else begin
          add_start_next = 1'b1;
          add_x1_next    = qx;
          add_y1_next    = qy;
          add_x2_next    = px_r;
          add_y2_next    = py_r;
        end
      end
      S_ADD_WAIT: begin
        if (add_done) begin
          qx_next    = add_x3;
          qy_next    = add_y3;
          q_inf_next = add_inf;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ecc_scalar_mult_ctrl.sv
// tb_ecc_scalar_mult_ctrl: directed bench on the curve y^2 = x^3 + 2x + 2 mod 17 with behavioural point units.
`timescale 1ns/1ps
module tb_ecc_scalar_mult_ctrl;

  localparam int unsigned N     = 8;
  localparam int          P_MOD = 17;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] k_in = '0;
  logic [N-1:0] px_in = '0;
  logic [N-1:0] py_in = '0;
  logic         busy, done, q_inf;
  logic [N-1:0] qx, qy;
  logic         dbl_start, add_start;
  logic [N-1:0] dbl_x, dbl_y, add_x1, add_y1, add_x2, add_y2;
  logic         dbl_done = 1'b0;
  logic [N-1:0] dbl_x3 = '0;
  logic [N-1:0] dbl_y3 = '0;
  logic         dbl_inf = 1'b0;
  logic         add_done = 1'b0;
  logic [N-1:0] add_x3 = '0;
  logic [N-1:0] add_y3 = '0;
  logic         add_inf = 1'b0;

  int total = 0;
  int bad = 0;
  int n_dbl = 0;
  int n_add = 0;
  int n_done = 0;
  bit overlap_mon = 1'b0;
  bit overlap_dbl = 1'b0;
  bit overlap_add = 1'b0;
  bit unstable_dbl = 1'b0;
  bit unstable_add = 1'b0;
  bit dbl_force_inf = 1'b0;
  bit rand_delay = 1'b0;
  bit dbl_hold = 1'b0;
  bit late_release = 1'b0;
  int fixed_delay = 1;

  ecc_scalar_mult_ctrl #(.n(N)) dut (
    .clk(clk), .reset(reset), .start(start),
    .k(k_in), .px(px_in), .py(py_in),
    .busy(busy), .done(done), .qx(qx), .qy(qy), .q_inf(q_inf),
    .dbl_start(dbl_start), .dbl_x(dbl_x), .dbl_y(dbl_y),
    .dbl_done(dbl_done), .dbl_x3(dbl_x3), .dbl_y3(dbl_y3), .dbl_inf(dbl_inf),
    .add_start(add_start), .add_x1(add_x1), .add_y1(add_y1), .add_x2(add_x2), .add_y2(add_y2),
    .add_done(add_done), .add_x3(add_x3), .add_y3(add_y3), .add_inf(add_inf)
  );

  initial forever #5 clk = ~clk;

  function automatic int md(input int a);
    return ((a % P_MOD) + P_MOD) % P_MOD;
  endfunction

  function automatic int inv(input int a);
    int r;
    r = 0;
    for (int i = 1; i < P_MOD; i++) if (md(a * i) == 1) r = i;
    return r;
  endfunction

  task automatic pt_dbl(input int x, input int y, input bit i,
                        output int x3, output int y3, output bit i3);
    int l;
    if (i || y == 0) begin
      x3 = 0; y3 = 0; i3 = 1'b1;
    end else begin
      l  = md((3 * x * x + 2) * inv(md(2 * y)));
      x3 = md(l * l - 2 * x);
      y3 = md(l * (x - x3) - y);
      i3 = 1'b0;
    end
  endtask

  task automatic pt_add(input int x1, input int y1, input bit i1,
                        input int x2, input int y2, input bit i2,
                        output int x3, output int y3, output bit i3);
    int l;
    if (i1) begin
      x3 = x2; y3 = y2; i3 = i2;
    end else if (i2) begin
      x3 = x1; y3 = y1; i3 = i1;
    end else if (x1 == x2) begin
      if (y1 == y2) pt_dbl(x1, y1, 1'b0, x3, y3, i3);
      else begin x3 = 0; y3 = 0; i3 = 1'b1; end
    end else begin
      l  = md((y2 - y1) * inv(md(x2 - x1)));
      x3 = md(l * l - x1 - x2);
      y3 = md(l * (x1 - x3) - y1);
      i3 = 1'b0;
    end
  endtask

  // Reference k*P by repeated addition, independent of the double-and-add order
  task automatic ref_mult(input int kk, input int x, input int y,
                          output int rx, output int ry, output bit ri);
    int ax, ay, tx, ty;
    bit ai, ti;
    ax = 0; ay = 0; ai = 1'b1;
    for (int j = 0; j < kk; j++) begin
      pt_add(ax, ay, ai, x, y, 1'b0, tx, ty, ti);
      ax = tx; ay = ty; ai = ti;
    end
    rx = ax; ry = ay; ri = ai;
  endtask

  function automatic int msb_pos(input int v);
    int m;
    m = 0;
    for (int b = 0; b < 32; b++) if (v[b]) m = b;
    return m;
  endfunction

  // Behavioural doubler: registered-style response after a programmable delay
  initial begin : dbl_unit
    int cx, cy, rx, ry, d;
    bit ri;
    forever begin
      @(negedge clk);
      if (dbl_start === 1'b1) begin
        cx = int'(dbl_x);
        cy = int'(dbl_y);
        pt_dbl(cx, cy, 1'b0, rx, ry, ri);
        if (dbl_force_inf) ri = 1'b1;
        if (dbl_hold) begin
          while (!late_release) @(negedge clk);
        end else begin
          d = rand_delay ? int'($urandom_range(0, 20)) : fixed_delay;
          repeat (d) begin
            @(negedge clk);
            if (int'(dbl_x) != cx || int'(dbl_y) != cy) unstable_dbl = 1'b1;
            if (dbl_start || add_start) overlap_dbl = 1'b1;
          end
        end
        dbl_x3   = N'(rx);
        dbl_y3   = N'(ry);
        dbl_inf  = ri;
        dbl_done = 1'b1;
        @(negedge clk);
        dbl_done = 1'b0;
      end
    end
  end

  // Behavioural adder
  initial begin : add_unit
    int cx1, cy1, cx2, cy2, rx, ry, d;
    bit ri;
    forever begin
      @(negedge clk);
      if (add_start === 1'b1) begin
        cx1 = int'(add_x1); cy1 = int'(add_y1);
        cx2 = int'(add_x2); cy2 = int'(add_y2);
        pt_add(cx1, cy1, 1'b0, cx2, cy2, 1'b0, rx, ry, ri);
        d = rand_delay ? int'($urandom_range(0, 20)) : fixed_delay;
        repeat (d) begin
          @(negedge clk);
          if (int'(add_x1) != cx1 || int'(add_y1) != cy1 ||
              int'(add_x2) != cx2 || int'(add_y2) != cy2) unstable_add = 1'b1;
          if (dbl_start || add_start) overlap_add = 1'b1;
        end
        add_x3   = N'(rx);
        add_y3   = N'(ry);
        add_inf  = ri;
        add_done = 1'b1;
        @(negedge clk);
        add_done = 1'b0;
      end
    end
  end

  // Event counters
  initial forever begin
    @(negedge clk);
    if (dbl_start === 1'b1) n_dbl++;
    if (add_start === 1'b1) n_add++;
    if (done === 1'b1) n_done++;
    if (dbl_start === 1'b1 && add_start === 1'b1) overlap_mon = 1'b1;
  end

  // Drives one multiplication; inputs are scrambled after the accept cycle to prove latching
  task automatic run_op(input int kk, input int x, input int y, input bit hold,
                        output bit ok, output int cyc, output int rx, output int ry, output bit rinf,
                        output bit done_after, output int hx, output int hy, output bit hinf,
                        output int nd, output int na, output int ndn);
    int d0, a0, c0;
    @(negedge clk);
    d0 = n_dbl; a0 = n_add; c0 = n_done;
    ok = 1'b0; cyc = 0;
    k_in = N'(kk); px_in = N'(x); py_in = N'(y); start = 1'b1;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(negedge clk);
      cyc++;
      if (!hold) start = 1'b0;
      k_in = N'(165); px_in = N'(3); py_in = N'(7);
      if (done === 1'b1) ok = 1'b1;
    end
    start = 1'b0;
    rx = int'(qx); ry = int'(qy); rinf = q_inf;
    @(negedge clk);
    done_after = done;
    repeat (3) @(negedge clk);
    hx = int'(qx); hy = int'(qy); hinf = q_inf;
    nd = n_dbl - d0; na = n_add - a0; ndn = n_done - c0;
  endtask

  task automatic test_reset();
    start = 1'b1; k_in = N'(6); px_in = N'(5); py_in = N'(1);
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if ({dbl_start, add_start, q_inf} !== 3'b000) begin
      bad++; $display("FAIL rst_flags: got %b want 000", {dbl_start, add_start, q_inf}); end
    total++; if ({qx, qy} !== '0) begin bad++; $display("FAIL rst_q: got %h want 0", {qx, qy}); end
    total++; if ({dbl_x, dbl_y, add_x1, add_y1, add_x2, add_y2} !== '0) begin
      bad++; $display("FAIL rst_operands: got %h want 0", {dbl_x, dbl_y, add_x1, add_y1, add_x2, add_y2}); end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_start_override: busy got %b want 0", busy); end
  endtask

  task automatic test_k6();
    bit ok, rinf, da, hinf;
    int cyc, rx, ry, hx, hy, nd, na, ndn;
    fixed_delay = 2;
    run_op(6, 5, 1, 1'b0, ok, cyc, rx, ry, rinf, da, hx, hy, hinf, nd, na, ndn);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL k6_done_timeout: got %b want 1", ok); end
    total++; if (rx != 16 || ry != 13) begin bad++; $display("FAIL k6_q: got (%0d,%0d) want (16,13)", rx, ry); end
    total++; if (rinf !== 1'b0) begin bad++; $display("FAIL k6_qinf: got %b want 0", rinf); end
    total++; if (nd != 2 || na != 1) begin bad++; $display("FAIL k6_unit_starts: got dbl=%0d add=%0d want dbl=2 add=1", nd, na); end
    total++; if (da !== 1'b0 || ndn != 1) begin bad++; $display("FAIL k6_done_pulse: got after=%b count=%0d want 0,1", da, ndn); end
    total++; if (hx != 16 || hy != 13 || hinf !== 1'b0) begin
      bad++; $display("FAIL k6_result_hold: got (%0d,%0d,%b) want (16,13,0)", hx, hy, hinf); end
  endtask

  task automatic test_k0();
    bit ok, rinf, da, hinf;
    int cyc, rx, ry, hx, hy, nd, na, ndn;
    run_op(0, 5, 1, 1'b0, ok, cyc, rx, ry, rinf, da, hx, hy, hinf, nd, na, ndn);
    total++; if (!ok || cyc != N + 1) begin bad++; $display("FAIL k0_latency: got ok=%b cycles=%0d want 1,%0d", ok, cyc, N + 1); end
    total++; if (rinf !== 1'b1) begin bad++; $display("FAIL k0_qinf: got %b want 1", rinf); end
    total++; if (nd != 0 || na != 0) begin bad++; $display("FAIL k0_unit_starts: got dbl=%0d add=%0d want 0,0", nd, na); end
  endtask

  task automatic test_k1_k3();
    bit ok, rinf, da, hinf;
    int cyc, rx, ry, hx, hy, nd, na, ndn;
    run_op(1, 5, 1, 1'b0, ok, cyc, rx, ry, rinf, da, hx, hy, hinf, nd, na, ndn);
    total++; if (!ok || rx != 5 || ry != 1 || rinf !== 1'b0) begin
      bad++; $display("FAIL k1_q: got ok=%b (%0d,%0d,%b) want (5,1,0)", ok, rx, ry, rinf); end
    total++; if (nd != 0 || na != 0) begin bad++; $display("FAIL k1_unit_starts: got dbl=%0d add=%0d want 0,0", nd, na); end
    run_op(3, 5, 1, 1'b0, ok, cyc, rx, ry, rinf, da, hx, hy, hinf, nd, na, ndn);
    total++; if (!ok || rx != 10 || ry != 6 || rinf !== 1'b0) begin
      bad++; $display("FAIL k3_q: got ok=%b (%0d,%0d,%b) want (10,6,0)", ok, rx, ry, rinf); end
    total++; if (nd != 1 || na != 1) begin bad++; $display("FAIL k3_unit_starts: got dbl=%0d add=%0d want 1,1", nd, na); end
  endtask

  task automatic test_inf_skip();
    bit ok, rinf, da, hinf;
    int cyc, rx, ry, hx, hy, nd, na, ndn;
    dbl_force_inf = 1'b1;
    run_op(5, 5, 1, 1'b0, ok, cyc, rx, ry, rinf, da, hx, hy, hinf, nd, na, ndn);
    dbl_force_inf = 1'b0;
    total++; if (!ok || rx != 5 || ry != 1 || rinf !== 1'b0) begin
      bad++; $display("FAIL inf_skip_q: got ok=%b (%0d,%0d,%b) want (5,1,0)", ok, rx, ry, rinf); end
    total++; if (nd != 1 || na != 0) begin bad++; $display("FAIL inf_skip_starts: got dbl=%0d add=%0d want 1,0", nd, na); end
  endtask

  task automatic test_back_to_back();
    int ks [5];
    bit ok, rinf, da, hinf, ei;
    int cyc, rx, ry, hx, hy, nd, na, ndn, ex, ey;
    ks = '{6, 19, 255, 13, 2};
    rand_delay = 1'b1;
    for (int t = 0; t < 5; t++) begin
      ref_mult(ks[t], 5, 1, ex, ey, ei);
      run_op(ks[t], 5, 1, 1'b1, ok, cyc, rx, ry, rinf, da, hx, hy, hinf, nd, na, ndn);
      total++; if (!ok || ndn != 1) begin
        bad++; $display("FAIL b2b_single_done k=%0d: got ok=%b dones=%0d want 1,1", ks[t], ok, ndn); end
      total++; if (rinf !== ei || (!ei && (rx != ex || ry != ey))) begin
        bad++; $display("FAIL b2b_q k=%0d: got (%0d,%0d,%b) want (%0d,%0d,%b)", ks[t], rx, ry, rinf, ex, ey, ei); end
      total++; if (nd != msb_pos(ks[t]) || na != $countones(ks[t]) - 1) begin
        bad++; $display("FAIL b2b_op_count k=%0d: got dbl=%0d add=%0d want %0d,%0d",
                        ks[t], nd, na, msb_pos(ks[t]), $countones(ks[t]) - 1); end
    end
    rand_delay = 1'b0;
    total++; if ({unstable_dbl, unstable_add} !== 2'b00) begin
      bad++; $display("FAIL operand_stability: got dbl=%b add=%b want 0,0", unstable_dbl, unstable_add); end
  endtask

  task automatic test_reset_mid();
    bit seen, saw_busy, saw_done, saw_late, ok, rinf, da, hinf;
    int cyc, rx, ry, hx, hy, nd, na, ndn;
    dbl_hold = 1'b1;
    seen = 1'b0;
    @(negedge clk);
    k_in = N'(6); px_in = N'(5); py_in = N'(1); start = 1'b1;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (dbl_start === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL mid_reach_dbl_wait: got %b want 1", seen); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    late_release = 1'b1;
    saw_busy = 1'b0; saw_done = 1'b0; saw_late = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0) saw_busy = 1'b1;
      if (done !== 1'b0) saw_done = 1'b1;
      if (dbl_done === 1'b1) saw_late = 1'b1;
    end
    total++; if (saw_late !== 1'b1) begin bad++; $display("FAIL mid_late_done_sent: got %b want 1", saw_late); end
    total++; if (saw_busy || saw_done) begin
      bad++; $display("FAIL mid_after_reset: got busy=%b done=%b want 0,0", saw_busy, saw_done); end
    total++; if ({qx, qy, q_inf, dbl_start, add_start} !== '0 ||
                 {dbl_x, dbl_y, add_x1, add_y1, add_x2, add_y2} !== '0) begin
      bad++; $display("FAIL mid_outputs_zero: got q=%h flags=%b ops=%h want 0", {qx, qy}, {q_inf, dbl_start, add_start},
                      {dbl_x, dbl_y, add_x1, add_y1, add_x2, add_y2}); end
    late_release = 1'b0;
    dbl_hold = 1'b0;
    run_op(3, 5, 1, 1'b0, ok, cyc, rx, ry, rinf, da, hx, hy, hinf, nd, na, ndn);
    total++; if (!ok || rx != 10 || ry != 6 || rinf !== 1'b0) begin
      bad++; $display("FAIL mid_recover_k3: got ok=%b (%0d,%0d,%b) want (10,6,0)", ok, rx, ry, rinf); end
  endtask

  task automatic test_protocol();
    total++; if ({overlap_mon, overlap_dbl, overlap_add} !== 3'b000) begin
      bad++; $display("FAIL start_exclusive: got %b want 000", {overlap_mon, overlap_dbl, overlap_add}); end
  endtask

  initial begin
    test_reset();
    test_k6();
    test_k0();
    test_k1_k3();
    test_inf_skip();
    test_back_to_back();
    test_reset_mid();
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ecc_scalar_mult_ctrl.md
ECC_SCALAR_MULT_CTRL -- requirements
Module: ecc_scalar_mult_ctrl

Interface
REQ-001 The block SHALL have parameter: n, 231, width of field elements and of scalar k.
REQ-002 The block SHALL have port: clk  input  1  single clock; all state changes on posedge clk.
REQ-003 The block SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port: start  input  1  request a scalar multiplication; sampled only in IDLE.
REQ-005 The block SHALL have ports: k, px, py  input  n each  scalar and base point P, latched on an accepted start.
REQ-006 The block SHALL have ports: busy  output  1; done  output  1  one-cycle completion pulse.
REQ-007 The block SHALL have ports: qx, qy  output  n  result Q = k*P; q_inf  output  1  result is point at infinity.
REQ-008 The block SHALL have ports: dbl_start  output  1; dbl_x, dbl_y  output  n  doubler operand.
REQ-009 The block SHALL have ports: dbl_done  input  1; dbl_x3, dbl_y3  input  n; dbl_inf  input  1  doubler result.
REQ-010 The block SHALL have ports: add_start  output  1; add_x1, add_y1, add_x2, add_y2  output  n  adder operands.
REQ-011 The block SHALL have ports: add_done  input  1; add_x3, add_y3  input  n; add_inf  input  1  adder result.

Function
REQ-012 The block SHALL use states IDLE, SCAN, DBL, DBL_WAIT, BIT, ADD, ADD_WAIT, FIN; busy = 1 in every state except IDLE.
REQ-013 IDLE: start=1 SHALL latch k/px/py, load bit index i = n-1, enter SCAN next cycle; start while busy SHALL be ignored.
REQ-014 SCAN: one bit per cycle; k[i]=1 -> Q=P, q_inf=0, then DBL if i>0, else FIN; k[i]=0 and i>0 -> i--; k[i]=0 and i=0 -> q_inf=1, FIN.
REQ-015 DBL: i--, then dbl_start SHALL pulse exactly one cycle with dbl_x/dbl_y = Q, then DBL_WAIT; if Q is infinity, no pulse, Q stays infinity, go to BIT.
REQ-016 DBL_WAIT: on dbl_done, Q <= (dbl_x3, dbl_y3), q_inf <= dbl_inf, go to BIT; else hold.
REQ-017 BIT: k[i]=1 -> ADD; k[i]=0 -> DBL if i>0, else FIN.
REQ-018 ADD: if Q is infinity, Q=P, q_inf=0 without pulse; else add_start SHALL pulse one cycle with (add_x1,add_y1)=Q, (add_x2,add_y2)=P, then ADD_WAIT.
REQ-019 ADD_WAIT: on add_done, Q <= (add_x3, add_y3), q_inf <= add_inf; next state DBL if i>0, else FIN.
REQ-020 FIN: done=1 for exactly one cycle, qx/qy/q_inf valid, return to IDLE.
REQ-021 qx/qy/q_inf SHALL hold their value from FIN until the next accepted start; intermediate values are not guaranteed valid while busy.
REQ-022 Operand outputs SHALL be registered and stable from the start pulse until the matching done.
REQ-023 dbl_done/add_done in any state other than the matching WAIT state SHALL be ignored.
REQ-024 At most one of dbl_start, add_start SHALL be high in any cycle; no new start SHALL issue before the prior done.
REQ-025 Bit index SHALL be $clog2(n) bits and SHALL never underflow below 0.
REQ-026 Operation count for k with MSB at position m SHALL be exactly m doublings (minus skipped infinity cases) and popcount(k)-1 additions.

Reset
REQ-027 reset=1 SHALL force IDLE; busy, done, dbl_start, add_start, q_inf = 0; qx, qy, all operand outputs = 0.
REQ-028 reset mid-operation SHALL abort immediately; late dbl_done/add_done after reset SHALL be ignored; reset overrides a simultaneous start.

Verification
REQ-029 Bench: n=8, curve y^2=x^3+2x+2 mod 17 with behavioural double/add models, P=(5,1), k=6 -> done, Q=(16,13), q_inf=0, 2 dbl_start, 1 add_start.
REQ-030 Bench: k=0 -> done after n+1 cycles from start, q_inf=1, no dbl_start or add_start.
REQ-031 Bench: k=1, P=(5,1) -> Q=(5,1), q_inf=0, no unit starts; k=3 -> Q=(10,6).
REQ-032 Bench: model forces dbl_inf=1 on first doubling, k=5 -> subsequent doubling skipped, add yields Q=P=(5,1).
REQ-033 Bench: start held high while busy and random-delay done responses (0-20 cycles) -> single result per accepted start, operands stable while waiting.
REQ-034 Bench: reset asserted during DBL_WAIT, then dbl_done pulsed -> stays IDLE, busy=0, done never asserted, outputs zero.
